div_unit: RTL and testbench

Iterative 32-bit divider for DIV/DIVU, instantiated inside the EX stage. It accepts operands from EX decode and stalls the front of the pipeline while it runs. It returns `{remainder, quotient}`, which EX places into the HI/LO fields of the EX→MEM hilo bus. The MEM stage then forwards that bus to WB and ID unchanged.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage iterative divider: stall bus layout, FSM states
// and result-ready levels.
package div_unit_pkg;

  localparam int unsigned StallBusWidth = 6;
  localparam int unsigned StallExMemBit = 3;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// sign fixup on the last step, result held in END until EX->MEM captures it.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [StallBusWidth-1:0] stall,
  input  logic                     annul_i,
  input  logic                     start_i,
  input  logic                     signed_i,
  input  logic [WIDTH-1:0]         opdata1_i,
  input  logic [WIDTH-1:0]         opdata2_i,
  output logic [2*WIDTH-1:0]       result_o,
  output logic                     ready_o,
  output logic                     stallreq_o
);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, dvd_next;

  logic unused_stall;
  assign unused_stall = ^{stall[StallBusWidth-1:StallExMemBit+1], stall[StallExMemBit-1:0]};

  // Trial subtraction of the divisor from the partial remainder plus next dividend bit.
  assign diff     = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign dvd_next = {dvd_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    if (annul_i) begin
      state_d = DivFree;
    end else begin
      case (state_q)
        DivFree: begin
          if (start_i) begin
            neg_quot_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d  = signed_i & opdata1_i[WIDTH-1];
            dsr_d      = (signed_i && opdata2_i[WIDTH-1]) ? {WIDTH{1'b0}} - opdata2_i
                                                           : opdata2_i;
            if (opdata2_i == '0) begin
              state_d = DivByZero;
            end else begin
              dvd_d   = (signed_i && opdata1_i[WIDTH-1]) ? {WIDTH{1'b0}} - opdata1_i
                                                         : opdata1_i;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = DivOn;
            end
          end
        end
        DivByZero: begin
          result_d = '0;
          state_d  = DivEnd;
        end
        DivOn: begin
          rem_d = rem_next;
          dvd_d = dvd_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH - 1)) begin
            result_d = {neg_rem_q  ? {WIDTH{1'b0}} - rem_next : rem_next,
                        neg_quot_q ? {WIDTH{1'b0}} - dvd_next : dvd_next};
            state_d  = DivEnd;
          end
        end
        DivEnd: begin
          // Leave only once EX->MEM has captured the result.
          if (stall[StallExMemBit] == NoStop) begin
            state_d = DivFree;
          end
        end
        default: state_d = DivFree;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign stallreq_o = start_i && (state_q != DivEnd) && !rst;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, a negedge monitor
// pops and compares whenever ready_o rises and while it stays high.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        annul_i, start_i, signed_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cur_exp = '0;
  logic        ready_prev = 1'b0;

  localparam logic [5:0] ExMemStop = 6'b001000;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .annul_i   (annul_i),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference: plain integer division; divide by zero yields zero.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {63'd0, ready_o}, 64'd0);
      end else begin
        cur_exp = exp_q.pop_front();
        check("result", result_o, cur_exp);
      end
    end else if (ready_o) begin
      check("result_hold", result_o, cur_exp);
    end
    ready_prev = ready_o;
  end

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int stop_cycles, input logic [63:0] expv);
    int n, sr_cnt, exp_lat;
    bit seen;
    @(posedge clk); #1;
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    stall     = (stop_cycles > 0) ? ExMemStop : 6'd0;
    exp_q.push_back(expv);
    exp_lat = (b == 32'd0) ? 2 : 33;
    n = 0; sr_cnt = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (ready_o) seen = 1;
      else begin
        if (stallreq_o) sr_cnt++;
        n++;
        // Already accepted: later operand changes must be ignored.
        if (n == 2) begin
          opdata1_i = $urandom;
          opdata2_i = $urandom;
          signed_i  = ~sgn;
        end
      end
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("stallreq_cycles", 64'(sr_cnt), 64'(exp_lat));
    check("stallreq_in_end", {63'd0, stallreq_o}, 64'd0);
    if (stop_cycles > 0) begin
      repeat (stop_cycles - 1) begin
        @(negedge clk);
        check("stalled_ready", {63'd0, ready_o}, 64'd1);
      end
      stall = 6'd0;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      check("release_idle", {63'd0, ready_o}, 64'd0);
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    start_i = 1'b0;
    stall   = 6'd0;
    repeat (k) @(negedge clk);
    check("idle_ready", {63'd0, ready_o}, 64'd0);
    check("idle_stallreq", {63'd0, stallreq_o}, 64'd0);
  endtask

  // kind 0: annul at T+10, kind 1: reset at T+10.
  task automatic abort_run(input int kind);
    int ready_hits, sr_bad;
    @(posedge clk); #1;
    start_i   = 1'b1;
    signed_i  = 1'($urandom);
    opdata1_i = $urandom;
    opdata2_i = $urandom | 32'd1;
    repeat (11) @(negedge clk);
    if (kind == 0) annul_i = 1'b1;
    else rst = 1'b1;
    @(negedge clk);
    if (kind == 0) begin
      check("annul_ready", {63'd0, ready_o}, 64'd0);
      check("annul_stallreq", {63'd0, stallreq_o}, 64'd1);
      // Start held together with annul in IDLE must not be accepted.
      @(negedge clk);
      check("annul_start_stallreq", {63'd0, stallreq_o}, 64'd1);
    end else begin
      check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      check("rst_mid_stallreq", {63'd0, stallreq_o}, 64'd0);
    end
    annul_i = 1'b0;
    rst     = 1'b0;
    start_i = 1'b0;
    ready_hits = 0; sr_bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (ready_o) ready_hits++;
      if (stallreq_o !== start_i) sr_bad++;
    end
    check("abort_no_ready", 64'(ready_hits), 64'd0);
    check("abort_stallreq_follows", 64'(sr_bad), 64'd0);
  endtask

  initial begin
    bit          sgn;
    logic [31:0] a, b;
    int          stop;
    rst = 1'b1; stall = 6'd0; annul_i = 1'b0; start_i = 1'b1; signed_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;

    run_div(1'b0, 32'd7, 32'd2, 0, 64'h00000001_00000003);
    idle(2);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 64'h00000000_80000000);
    run_div(1'b0, 32'd5, 32'd0, 0, 64'd0);
    idle(1);
    run_div(1'b0, 32'd100, 32'd7, 3, 64'h00000002_0000000E);
    run_div(1'b0, 32'd9, 32'd4, 0, 64'h00000001_00000002);
    idle(2);
    abort_run(0);
    abort_run(1);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 9));
        3:       b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_div(sgn, a, b, stop, model(sgn, a, b));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
